// File: rtl/seq_alu_if.sv
// rtl/seq_alu_if.sv - operation request / result handshake bundle for seq_alu
interface seq_alu_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [2:0]       s;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] alu_out;
    logic             alu_cout;
    logic             zero;
    logic             neg;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, s, out_ready,
        input  in_ready, out_valid, alu_out, alu_cout, zero, neg, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, s, out_ready,
        output in_ready, out_valid, alu_out, alu_cout, zero, neg, ovf
    );
endinterface

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - handshaked ALU: single-cycle ops, WIDTH-cycle shift-add multiply
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    seq_alu_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

    state_t             state;
    state_t             state_nxt;
    logic               accept;
    logic               is_mul;
    logic               calc_done;
    logic [WIDTH:0]     wide;
    logic [WIDTH-1:0]   res_c;
    logic               cout_c;
    logic               ovf_c;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_nxt;
    logic [WIDTH:0]     psum;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   alu_out_r;
    logic               alu_cout_r;
    logic               zero_r;
    logic               neg_r;
    logic               ovf_r;

    assign accept    = bus.in_valid && bus.in_ready;
    assign is_mul    = (bus.s == 3'b111);
    assign calc_done = (state == CALC) && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A HOLD with the consumer ready behaves exactly like IDLE for a new request.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (accept) state_nxt = is_mul ? CALC : HOLD;
            end
            CALC: begin
                if (calc_done) state_nxt = HOLD;
            end
            HOLD: begin
                if (bus.out_ready) begin
                    if (accept) state_nxt = is_mul ? CALC : HOLD;
                    else        state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        unique case (state)
            IDLE: bus.in_ready = 1'b1;
            CALC: bus.in_ready = 1'b0;
            HOLD: begin
                bus.in_ready  = bus.out_ready;
                bus.out_valid = 1'b1;
            end
            default: bus.in_ready = 1'b0;
        endcase
    end

    always_comb begin
        wide   = '0;
        res_c  = '0;
        cout_c = 1'b0;
        ovf_c  = 1'b0;
        unique case (bus.s)
            3'b000: begin
                wide   = {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.cin};
                res_c  = wide[WIDTH-1:0];
                cout_c = wide[WIDTH];
                ovf_c  = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (res_c[WIDTH-1] != bus.a[WIDTH-1]);
            end
            3'b001: begin
                // Bit WIDTH of the extended difference is the borrow.
                wide   = {1'b0, bus.a} - {1'b0, bus.b} - {{WIDTH{1'b0}}, bus.cin};
                res_c  = wide[WIDTH-1:0];
                cout_c = wide[WIDTH];
                ovf_c  = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (res_c[WIDTH-1] != bus.a[WIDTH-1]);
            end
            3'b010: res_c = bus.a & bus.b;
            3'b011: res_c = bus.a | bus.b;
            3'b100: res_c = bus.a ^ bus.b;
            3'b101: begin
                res_c  = {bus.a[WIDTH-2:0], bus.cin};
                cout_c = bus.a[WIDTH-1];
            end
            3'b110: begin
                res_c  = {bus.cin, bus.a[WIDTH-1:1]};
                cout_c = bus.a[0];
            end
            default: res_c = '0;
        endcase
    end

    // Upper half accumulates, lower half holds the shrinking multiplier.
    always_comb begin
        psum     = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
        prod_nxt = {psum, prod[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand      <= '0;
            prod       <= '0;
            cnt        <= '0;
            alu_out_r  <= '0;
            alu_cout_r <= 1'b0;
            zero_r     <= 1'b0;
            neg_r      <= 1'b0;
            ovf_r      <= 1'b0;
        end else begin
            if (accept && is_mul) begin
                mcand <= bus.a;
                prod  <= {{WIDTH{1'b0}}, bus.b};
                cnt   <= '0;
            end else if (state == CALC) begin
                prod  <= prod_nxt;
                cnt   <= cnt + 1'b1;
            end

            if (accept && !is_mul) begin
                alu_out_r  <= res_c;
                alu_cout_r <= cout_c;
                zero_r     <= (res_c == '0);
                neg_r      <= res_c[WIDTH-1];
                ovf_r      <= ovf_c;
            end else if (calc_done) begin
                alu_out_r  <= prod_nxt[WIDTH-1:0];
                alu_cout_r <= |prod_nxt[2*WIDTH-1:WIDTH];
                zero_r     <= (prod_nxt[WIDTH-1:0] == '0);
                neg_r      <= prod_nxt[WIDTH-1];
                ovf_r      <= 1'b0;
            end
        end
    end

    assign bus.alu_out  = alu_out_r;
    assign bus.alu_cout = alu_cout_r;
    assign bus.zero     = zero_r;
    assign bus.neg      = neg_r;
    assign bus.ovf      = ovf_r;
endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - randomized and directed checks of seq_alu against an arithmetic model
module tb_seq_alu;
    localparam int W = 8;

    typedef struct {
        int res;
        int cout;
        int zero;
        int neg;
        int ovf;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    seq_alu_if #(.WIDTH(W)) bus ();
    seq_alu #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic int sgn(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    function automatic exp_t model(input int op, input int a, input int b, input int c);
        exp_t e;
        int   t;
        int   st;
        e = '{0, 0, 0, 0, 0};
        case (op)
            0: begin
                t = a + b + c;  st = sgn(a) + sgn(b) + c;
                e.res = t % 256; e.cout = int'(t > 255); e.ovf = int'(st > 127 || st < -128);
            end
            1: begin
                t = a - b - c;  st = sgn(a) - sgn(b) - c;
                e.res = (t + 256) % 256; e.cout = int'(a < b + c); e.ovf = int'(st > 127 || st < -128);
            end
            2: e.res = a & b;
            3: e.res = a | b;
            4: e.res = a ^ b;
            5: begin e.res = (a * 2 + c) % 256; e.cout = a / 128; end
            6: begin e.res = c * 128 + a / 2; e.cout = a % 2; end
            default: begin t = a * b; e.res = t % 256; e.cout = int'(t > 255); end
        endcase
        e.zero = int'(e.res == 0);
        e.neg  = e.res / 128;
        return e;
    endfunction

    task automatic check_out(input string tag, input exp_t e);
        check({tag, ".out"},  32'(bus.alu_out),  32'(e.res));
        check({tag, ".cout"}, 32'(bus.alu_cout), 32'(e.cout));
        check({tag, ".zero"}, 32'(bus.zero),     32'(e.zero));
        check({tag, ".neg"},  32'(bus.neg),      32'(e.neg));
        check({tag, ".ovf"},  32'(bus.ovf),      32'(e.ovf));
    endtask

    task automatic drive(input int op, input int a, input int b, input int c);
        bus.in_valid = 1'b1;
        bus.s   = 3'(op);
        bus.a   = 8'(a);
        bus.b   = 8'(b);
        bus.cin = 1'(c);
    endtask

    task automatic scramble();
        bus.s   = 3'($urandom());
        bus.a   = 8'($urandom());
        bus.b   = 8'($urandom());
        bus.cin = 1'($urandom());
    endtask

    // Issue one op, corrupt the inputs after accept, wait for the result.
    task automatic run_op(input string tag, input int op, input int a, input int b, input int c);
        exp_t e;
        int   lat;
        e = model(op, a, b, c);
        drive(op, a, b, c);
        check({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        lat = 1;
        bus.in_valid = 1'b0;
        scramble();
        while (!bus.out_valid && lat < 50) begin
            check({tag, ".calc_ready"}, 32'(bus.in_ready), 32'd0);
            bus.in_valid = 1'b1;
            scramble();
            @(posedge clk); #1;
            lat++;
        end
        bus.in_valid = 1'b0;
        check({tag, ".latency"}, 32'(lat), (op == 7) ? 32'd9 : 32'd1);
        check_out(tag, e);
    endtask

    initial begin
        exp_t e;
        exp_t sq[4];
        int   op, a, b, c;
        logic seen;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.s = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.out_valid", 32'(bus.out_valid), 32'd0);
        check_out("rst", '{0, 0, 0, 0, 0});
        rst_n = 1'b1;
        #1;
        check("rst.in_ready", 32'(bus.in_ready), 32'd1);

        run_op("add_4_2",    0, 8'h04, 8'h02, 0);
        run_op("add_ff_1",   0, 8'hFF, 8'h01, 0);
        run_op("add_7f_1",   0, 8'h7F, 8'h01, 0);
        run_op("sub_2_4",    1, 8'h02, 8'h04, 0);
        run_op("shl_81",     5, 8'h81, 8'h00, 1);
        run_op("shr_01",     6, 8'h01, 8'h00, 1);
        run_op("mul_10_10",  7, 8'h10, 8'h10, 0);
        run_op("mul_0f_03",  7, 8'h0F, 8'h03, 0);

        for (int i = 0; i < 40; i++) begin
            op = int'($urandom_range(0, 7));
            a  = int'($urandom_range(0, 255));
            b  = int'($urandom_range(0, 255));
            c  = int'($urandom_range(0, 1));
            run_op($sformatf("rnd%0d_op%0d", i, op), op, a, b, c);
        end

        // Stall in HOLD, then stream four ADDs back to back.
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        run_op("stall", 0, 8'h55, 8'h22, 1);
        e = model(0, 8'h55, 8'h22, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("stall.out_valid", 32'(bus.out_valid), 32'd1);
            check("stall.in_ready",  32'(bus.in_ready),  32'd0);
            check_out("stall", e);
        end
        for (int i = 0; i < 4; i++) sq[i] = model(0, 16 * i + 3, 8'h40 + i, i % 2);
        bus.out_ready = 1'b1;
        drive(0, 3, 8'h40, 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check($sformatf("stream%0d.out_valid", i), 32'(bus.out_valid), 32'd1);
            check_out($sformatf("stream%0d", i), sq[i]);
            if (i < 3) drive(0, 16 * (i + 1) + 3, 8'h40 + i + 1, (i + 1) % 2);
            else bus.in_valid = 1'b0;
        end

        // Reset three cycles into a multiply; its result must never appear.
        run_op("pre_rst", 0, 8'h7F, 8'h01, 0);
        drive(7, 8'h33, 8'h05, 0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check("mrst.out_valid", 32'(bus.out_valid), 32'd0);
        check_out("mrst", '{0, 0, 0, 0, 0});
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("mrst.in_ready", 32'(bus.in_ready), 32'd1);
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen = 1'b1;
        end
        check("mrst.no_result", 32'(seen), 32'd0);
        run_op("post_rst_add", 0, 8'h04, 8'h02, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
